// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: shared ImmSrc encodings, FSM states and immediate packing helpers
package imm_encoder_pkg;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_e;

  // Both 10 and 11 select the B layout.
  function automatic logic [31:0] pack_imm(input logic [31:0] tmpl, input logic [31:0] imm,
                                           input logic [1:0] src);
    logic [31:0] w;
    w = tmpl;
    if (src >= IMM_B) begin
      w[31]    = imm[12];
      w[7]     = imm[11];
      w[30:25] = imm[10:5];
      w[11:8]  = imm[4:1];
    end else if (src == IMM_S) begin
      w[31:25] = imm[11:5];
      w[11:7]  = imm[4:0];
    end else if (src == IMM_I) begin
      w[31:20] = imm[11:0];
    end
    return w;
  endfunction

  function automatic logic imm_fits(input logic [31:0] imm, input logic [1:0] src);
    return (src >= IMM_B) ? ((&imm[31:12] | ~|imm[31:12]) & ~imm[0])
                          : (&imm[31:11] | ~|imm[31:11]);
  endfunction
endpackage

// File: rtl/imm_encoder_pack.sv
// imm_pack: combinational immediate scatter plus legality flag
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] imm,
  input  logic [1:0]  src,
  output logic [31:0] word,
  output logic        fits
);
  assign word = pack_imm(instr, imm, src);
  assign fits = imm_fits(imm, src);
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: packs immediates into instruction templates and streams them into instruction memory
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [1:0]            in_ImmSrc,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-2:0] word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-2:0] WC_ONE = (ADDR_WIDTH-1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d, err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-2:0] word_count_q, word_count_d;
  logic                  mem_we_q, mem_we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0]           packed_word;
  logic                  fits, accept, go, wrap;

  imm_pack u_pack (
    .instr(in_instr),
    .imm  (in_imm),
    .src  (in_ImmSrc),
    .word (packed_word),
    .fits (fits)
  );

  always_comb begin
    accept       = in_valid && state_q == ST_RUN;
    go           = start && (state_q == ST_IDLE || state_q == ST_DONE);
    wrap         = &addr_q[ADDR_WIDTH-1:2] && !in_last;
    state_d      = state_q;
    addr_d       = addr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    err_addr_d   = err_addr_q;
    done_d       = done_q;
    mem_we_d     = accept;
    if (go) begin
      state_d      = ST_RUN;
      addr_d       = base_addr & ADDR_MASK;
      word_count_d = '0;
      err_d        = 1'b0;
      err_addr_d   = '0;
      done_d       = 1'b0;
    end
    if (accept) begin
      mem_addr_d   = addr_q;
      mem_wdata_d  = packed_word;
      addr_d       = addr_q + ADDR_STEP;
      word_count_d = word_count_q + WC_ONE;
      // A bad immediate blames its own word; a pure wrap blames the wrapped-to address 0.
      if (!fits || wrap) begin
        err_d      = 1'b1;
        err_addr_d = err_q ? err_addr_q : (fits ? '0 : addr_q);
      end
      if (in_last) begin
        state_d = ST_FLUSH;
        done_d  = 1'b1;
      end
    end
    if (state_q == ST_FLUSH) state_d = ST_DONE;
    busy_d = state_d == ST_RUN || state_d == ST_FLUSH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      err_addr_q   <= err_addr_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign in_ready   = state_q == ST_RUN;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = word_count_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_addr   = err_addr_q;
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and random scoreboard bench for imm_encoder, plus a 4-bit-address wrap instance
module tb_imm_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [11:0] base_addr = '0;
  logic [31:0] in_instr = '0, in_imm = '0;
  logic [1:0]  in_src = '0;
  logic        in_ready, mem_we, busy, done, err;
  logic [11:0] mem_addr, err_addr;
  logic [31:0] mem_wdata;
  logic [10:0] word_count;

  logic        w_start = 1'b0, w_valid = 1'b0, w_last = 1'b0;
  logic [3:0]  w_base = '0;
  logic        w_ready, w_we, w_busy, w_done, w_err;
  logic [3:0]  w_addr, w_err_addr;
  logic [31:0] w_data;
  logic [2:0]  w_wc;

  int checks = 0, errors = 0;
  bit acc_exp = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] word;
    logic [31:0] imm;
    logic [31:0] tmpl;
    logic [1:0]  src;
    bit          use_w;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  imm_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) u_dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_instr(in_instr), .in_imm(in_imm),
    .in_ImmSrc(in_src), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .busy(busy), .done(done), .err(err), .err_addr(err_addr)
  );

  imm_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) u_wrap (
    .clk(clk), .rst(rst), .start(w_start), .base_addr(w_base), .in_valid(w_valid),
    .in_ready(w_ready), .in_last(w_last), .in_instr(in_instr), .in_imm(in_imm),
    .in_ImmSrc(in_src), .mem_we(w_we), .mem_addr(w_addr), .mem_wdata(w_data),
    .word_count(w_wc), .busy(w_busy), .done(w_done), .err(w_err), .err_addr(w_err_addr)
  );

  function automatic logic [31:0] dec(input logic [31:0] w, input logic [1:0] src);
    if (src[1]) return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    if (src[0]) return {{20{w[31]}}, w[31:25], w[11:7]};
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [31:0] keep(input logic [1:0] src);
    return (src == 2'b00) ? 32'h000F_FFFF : 32'h01FF_F07F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (acc_exp) begin
      chk("we", 32'(mem_we), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("addr", 32'(mem_addr), 32'(e.addr));
        if (e.use_w) chk("word", mem_wdata, e.word);
        else begin
          chk("roundtrip", dec(mem_wdata, e.src), e.imm);
          chk("template", mem_wdata & keep(e.src), e.tmpl & keep(e.src));
        end
      end
    end else chk("no_we", 32'(mem_we), 32'd0);
    acc_exp = 0;
  endtask

  task automatic drive(input bit last, input logic [31:0] t, input logic [31:0] imm,
                       input logic [1:0] src, input logic [11:0] a, input logic [31:0] w,
                       input bit use_w);
    in_valid = 1'b1;
    in_last  = last;
    in_instr = t;
    in_imm   = imm;
    in_src   = src;
    sbq.push_back('{a, w, imm, t, src, use_w});
    acc_exp = 1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [31:0] r, imm;
    logic [1:0]  src;
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wc", 32'(word_count), 0);
    chk("rst_err_addr", 32'(err_addr), 0);
    rst = 1'b1;
    in_valid = 1'b1;
    step();
    chk("idle_ready", 32'(in_ready), 0);
    in_valid = 1'b0;

    start = 1'b1; base_addr = 12'h100;
    step();
    start = 1'b0;
    chk("run_ready", 32'(in_ready), 1);
    chk("run_busy", 32'(busy), 1);
    drive(0, 32'h0000_0013, 32'hFFFF_FFFF, 2'b00, 12'h100, 32'hFFF0_0013, 1);
    drive(0, 32'h0000_2023, 32'd8, 2'b01, 12'h104, 32'h0000_2423, 1);
    drive(1, 32'h0000_0063, 32'hFFFF_FFFC, 2'b10, 12'h108, 32'hFE00_0EE3, 1);
    chk("s1_done", 32'(done), 1);
    chk("s1_wc", 32'(word_count), 3);
    chk("s1_err", 32'(err), 0);
    chk("s1_flush_busy", 32'(busy), 1);
    step();
    chk("s1_done_busy", 32'(busy), 0);
    in_valid = 1'b1;
    chk("done_ready", 32'(in_ready), 0);
    step();
    in_valid = 1'b0;

    start = 1'b1; base_addr = 12'h203;
    step();
    start = 1'b0;
    chk("s2_done_clr", 32'(done), 0);
    chk("s2_wc_clr", 32'(word_count), 0);
    drive(0, 32'h0000_0013, 32'd2048, 2'b00, 12'h200, 32'h8000_0013, 1);
    chk("s2_err", 32'(err), 1);
    chk("s2_err_addr", 32'(err_addr), 32'h200);
    start = 1'b1; base_addr = 12'h300;
    step();
    start = 1'b0;
    chk("s2_ign_ready", 32'(in_ready), 1);
    drive(0, 32'h0000_0063, 32'd3, 2'b11, 12'h204, 32'h0000_0163, 1);
    chk("s2_err_keep", 32'(err), 1);
    chk("s2_err_addr_keep", 32'(err_addr), 32'h200);
    drive(0, 32'h0000_0013, 32'd7, 2'b00, 12'h208, 32'h0070_0013, 1);
    step();
    drive(1, 32'h0000_2023, 32'hFFFF_FFF8, 2'b01, 12'h20C, 32'hFE00_2C23, 1);
    chk("s2_done", 32'(done), 1);
    chk("s2_wc", 32'(word_count), 4);
    step();

    start = 1'b1; base_addr = 12'h400;
    step();
    start = 1'b0;
    chk("s3_err_clr", 32'(err), 0);
    chk("s3_err_addr_clr", 32'(err_addr), 0);
    for (int i = 0; i < 24; i++) begin
      r   = $urandom;
      src = 2'($urandom_range(0, 3));
      imm = src[1] ? {{19{r[12]}}, r[12:1], 1'b0} : {{20{r[11]}}, r[11:0]};
      drive(i == 23, $urandom, imm, src, 12'h400 + 12'(4 * i), 32'd0, 0);
    end
    chk("s3_err", 32'(err), 0);
    chk("s3_wc", 32'(word_count), 24);
    step();

    w_start = 1'b1; w_base = 4'hD;
    step();
    w_start = 1'b0;
    chk("w_ready", 32'(w_ready), 1);
    w_valid = 1'b1; in_instr = 32'h13; in_imm = 32'd1; in_src = 2'b00;
    step();
    chk("w_we0", 32'(w_we), 1);
    chk("w_addr0", 32'(w_addr), 32'hC);
    chk("w_data0", w_data, 32'h0010_0013);
    chk("w_err", 32'(w_err), 1);
    chk("w_err_addr0", 32'(w_err_addr), 0);
    w_last = 1'b1; in_imm = 32'd2;
    step();
    w_valid = 1'b0; w_last = 1'b0;
    chk("w_we1", 32'(w_we), 1);
    chk("w_addr1", 32'(w_addr), 0);
    chk("w_data1", w_data, 32'h0020_0013);
    chk("w_done", 32'(w_done), 1);
    chk("w_err_addr1", 32'(w_err_addr), 0);
    chk("w_wc", 32'(w_wc), 2);

    start = 1'b1; base_addr = 12'h500;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_instr = 32'h13; in_imm = 32'd5; in_src = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mr_we", 32'(mem_we), 0);
    chk("mr_addr", 32'(mem_addr), 0);
    chk("mr_wdata", mem_wdata, 0);
    chk("mr_wc", 32'(word_count), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_err", 32'(err), 0);
    chk("mr_err_addr", 32'(err_addr), 0);
    chk("mr_ready", 32'(in_ready), 0);
    rst = 1'b1;
    step();
    chk("mr_idle_ready", 32'(in_ready), 0);
    chk("sb_empty", 32'(sbq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
